dmem_request_queue: RTL
=======================

# dmem_request_queue

Parametrised data-memory request unit between the pipeline's memory stage and the data cache. Captures load/store requests on an instruction hit and holds them in a DEPTH-entry in-order queue. Presents the head entry to the cache as a held dREN/dWEN request until dhit, and returns tagged load data. Supports pipeline flush, and optionally a watchdog on stuck cache transactions.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_W, 5, load destination tag width
- DEPTH, 4, queue entries; power of two, >= 2
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the macro under Configuration
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; synchronous, active-high
- ihit  in  1  instruction hit; qualifies enqueue
- memtoReg  in  1  load request
- memWr  in  1  store request
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  store data
- tag  in  TAG_W  load destination tag
- flush  in  1  squash queued requests
- dhit  in  1  cache completes the head request
- dload  in  DATA_W  cache read data, valid with dhit
- dREN  out  1  head is a read
- dWEN  out  1  head is a write
- daddr  out  ADDR_W  head address
- dstore  out  DATA_W  head store data
- rvalid  out  1  one-cycle load-return pulse
- rdata  out  DATA_W  returned load data
- rtag  out  TAG_W  returned load tag
- full  out  1  count == DEPTH; pipeline must stall
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupancy
- timeout  out  1  sticky watchdog flag

## Operation
- Enqueue condition: ihit && (memtoReg || memWr) && !full && !flush.
  - memtoReg has priority: if both are set, the entry is a read and memWr is ignored.
  - Each entry stores op, addr, wdata and tag.
- If ihit and a request arrive while full, the request is dropped and no entry is written. The pipeline must stall on full.
- The head entry drives daddr, dstore and the op. dREN = head valid && read; dWEN = head valid && write. The two are never both 1.
- dREN/dWEN, daddr and dstore stay stable from the cycle the head becomes valid until the dhit cycle inclusive.
- Pop on dhit && !empty. A dhit while empty is ignored.
- On popping a non-squashed read: the next cycle has rvalid=1, rdata=dload sampled at the dhit edge, rtag=head tag.
- A write pop produces no return.
- Enqueue and pop in the same cycle: count is unchanged. This is legal only when not full, since full blocks enqueue.
- Pointers wrap modulo DEPTH.
- Flush:
  - Discards every entry except the head.
  - If the head is valid, it is kept in flight, because a cache transaction is never aborted. It is marked squashed and its return is suppressed.
  - After flush, count = (head valid ? 1 : 0).
- Flush in the same cycle as dhit: the head pops, no rvalid is produced, and the queue is empty next cycle.
- Flush in the same cycle as an enqueue: the enqueue is dropped.

## Timing
- Reset (RST high at an edge): queue empty and squash bit cleared.
  - Outputs: dREN=0, dWEN=0, daddr=0, dstore=0, rvalid=0, rdata=0, rtag=0, full=0, empty=1, count=0, timeout=0.
- RST overrides every other input in the same cycle. Reset mid-transaction drops the in-flight request; the cache must also be reset.
- Request latency: a request enqueued into an empty queue at edge N drives dREN/dWEN from edge N onward, with no added cycle.
- Back-to-back: dhit at edge M pops the head, and the next entry drives the cache from edge M with no bubble.
- Return latency: rvalid is high for exactly one cycle, starting at the edge after the dhit edge.
- full, empty and count are registered and reflect state after the current edge.

## Configuration
- DMEM_REQ_TIMEOUT_EN defined:
  - A cycle counter runs while the head is valid and is cleared on each pop.
  - When the counter reaches TIMEOUT_CYCLES, timeout is set and stays set until RST. Queue behaviour is unchanged.
- Not defined: no counter logic is built and timeout is tied to 0.

## Test plan
- Load then store, DEPTH=4: load addr 0x100 with tag 3, then store addr 0x104 with data 0xDEADBEEF; dhit after 2 cycles each.
  - dREN=1 with daddr=0x100 until the first dhit.
  - Next cycle: rvalid=1, rdata=dload, rtag=3.
  - dWEN=1 with daddr=0x104 and dstore=0xDEADBEEF from the edge of the first pop.
- Fill and overflow: 5 requests on consecutive ihit with no dhit.
  - count reaches 4 and full=1.
  - The 5th request is not stored; after 4 dhits the 4 original addresses are popped in order and empty=1.
- Both memtoReg and memWr set: the entry is a read, so dREN=1 and dWEN=0.
- Flush with 3 entries and head a read: count becomes 1; the subsequent dhit gives no rvalid and empty=1.
- Wrap-around and timeout:
  - 10 requests with interleaved dhit give correct FIFO order across pointer wrap.
  - With DMEM_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, holding dhit low 8 cycles sets timeout=1; it stays set until RST.

Source files
------------

// File: rtl/dmem_request_queue.sv
// -----------------------------------------------------------------------------
// dmem_request_queue
//
// Data-memory request unit sitting between the pipeline memory stage and the
// data cache. Load/store requests are captured on ihit into a DEPTH-entry
// in-order queue. The head entry is presented to the cache as a held
// dREN/dWEN request until dhit, and load data is returned with its tag one
// cycle after the completing dhit.
//
// Optional build macro: DMEM_REQ_TIMEOUT_EN
//    defined   - a watchdog counts cycles while the head is valid (cleared on
//                every pop) and sets the sticky timeout flag when the count
//                reaches TIMEOUT_CYCLES.
//    undefined - no watchdog logic; timeout is tied low.
//
// Ports
//    CLK, RST          clock, synchronous active-high reset
//    ihit              instruction hit, qualifies enqueue
//    memtoReg, memWr   load / store request (load wins if both set)
//    addr, wdata, tag  request address, store data, load destination tag
//    flush             squash every queued request except the in-flight head
//    dhit, dload       cache completion and read data for the head request
//    dREN, dWEN        head request is a read / write
//    daddr, dstore     head address / head store data
//    rvalid, rdata,    one-cycle load return pulse, data and tag
//    rtag
//    full, empty,      occupancy status (count == DEPTH, count == 0, count)
//    count
//    timeout           sticky watchdog flag
// -----------------------------------------------------------------------------
module dmem_request_queue #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TAG_W          = 5,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         ihit,
   input  logic                         memtoReg,
   input  logic                         memWr,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [TAG_W-1:0]             tag,
   input  logic                         flush,
   input  logic                         dhit,
   input  logic [DATA_W-1:0]            dload,
   output logic                         dREN,
   output logic                         dWEN,
   output logic [ADDR_W-1:0]            daddr,
   output logic [DATA_W-1:0]            dstore,
   output logic                         rvalid,
   output logic [DATA_W-1:0]            rdata,
   output logic [TAG_W-1:0]             rtag,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         timeout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Entry storage; only the enqueue path writes it, so it needs no reset.
   logic              op_rd_q [DEPTH];
   logic [ADDR_W-1:0] addr_q  [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [TAG_W-1:0]  tag_q   [DEPTH];

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              squash_q, squash_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [TAG_W-1:0]  rtag_q, rtag_d;

   logic head_valid;
   logic head_rd;
   logic is_full;
   logic enq;
   logic pop;

   assign head_valid = (count_q != '0);
   assign head_rd    = op_rd_q[rd_ptr_q];
   assign is_full    = (count_q == CNT_W'(DEPTH));
   assign enq        = ihit && (memtoReg || memWr) && !is_full && !flush;
   assign pop        = dhit && head_valid;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      squash_d = squash_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rtag_d   = rtag_q;

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         squash_d = 1'b0;
         // A squashed head, or one flushed on its completing cycle, returns nothing.
         if (head_rd && !squash_q && !flush) begin
            rvalid_d = 1'b1;
            rdata_d  = dload;
            rtag_d   = tag_q[rd_ptr_q];
         end
      end

      if (flush) begin
         if (head_valid && !pop) begin
            // The cache transaction cannot be aborted: keep the head alone,
            // mark it squashed so its return is suppressed.
            wr_ptr_d = rd_ptr_q + 1'b1;
            count_d  = CNT_W'(1);
            squash_d = 1'b1;
         end else begin
            // Queue drains completely (also a no-op when already empty).
            wr_ptr_d = rd_ptr_d;
            count_d  = '0;
         end
      end else begin
         if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         squash_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rtag_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         squash_q <= squash_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rtag_q   <= rtag_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && enq) begin
         op_rd_q[wr_ptr_q] <= memtoReg;
         addr_q[wr_ptr_q]  <= addr;
         data_q[wr_ptr_q]  <= wdata;
         tag_q[wr_ptr_q]   <= tag;
      end
   end

   // Head drives the cache straight from storage, so a request enqueued into
   // an empty queue is visible right after its enqueue edge.
   assign dREN   = head_valid && head_rd;
   assign dWEN   = head_valid && !head_rd;
   assign daddr  = head_valid ? addr_q[rd_ptr_q] : '0;
   assign dstore = head_valid ? data_q[rd_ptr_q] : '0;

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign rtag   = rtag_q;
   assign full   = is_full;
   assign empty  = !head_valid;
   assign count  = count_q;

`ifdef DMEM_REQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (pop) begin
         wd_cnt_d = '0;
      end else if (head_valid && (wd_cnt_q != WD_W'(TIMEOUT_CYCLES))) begin
         // Saturates at the limit so a stuck head cannot wrap the counter.
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
      timeout_d = timeout_q || (wd_cnt_d == WD_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   // Watchdog not built; the limit parameter has no effect in this build.
   assign timeout = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule
